// File: rtl/dl11_regs_if.sv
// I/O-page bus bundle between the CPU I/O-page decoder and the DL11 register block.
interface dl11_regs_if;
  logic [12:0] iopage_addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        iopage_rd;
  logic        iopage_wr;
  logic        iopage_byte_op;
  logic        decode;

  modport master (
    output iopage_addr, data_in, iopage_rd, iopage_wr, iopage_byte_op,
    input  data_out, decode
  );

  modport slave (
    input  iopage_addr, data_in, iopage_rd, iopage_wr, iopage_byte_op,
    output data_out, decode
  );
endinterface

// File: rtl/dl11_regs.sv
// DL11 console register set (RCSR/RBUF/XCSR/XBUF) with four-phase load/unload
// handshakes toward the uart block and level receive/transmit interrupts.
module dl11_regs #(
  parameter logic [12:0] BASE_ADDR = 13'o17560
) (
  input  logic              clk,
  input  logic              reset,
  dl11_regs_if.slave        bus,
  output logic              interrupt_rx,
  output logic              interrupt_tx,
  output logic              ld_tx_req,
  input  logic              ld_tx_ack,
  output logic [7:0]        tx_data,
  input  logic              tx_empty,
  output logic              uld_rx_req,
  input  logic              uld_rx_ack,
  input  logic [7:0]        rx_data,
  input  logic              rx_empty
);

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_REQ   = 2'd1;
  localparam logic [1:0] R_ACK   = 2'd2;

  localparam logic [1:0] T_IDLE  = 2'd0;
  localparam logic [1:0] T_REQ   = 2'd1;
  localparam logic [1:0] T_ACK   = 2'd2;
  localparam logic [1:0] T_DRAIN = 2'd3;

  localparam logic [1:0] SEL_RCSR = 2'd0;
  localparam logic [1:0] SEL_RBUF = 2'd1;
  localparam logic [1:0] SEL_XCSR = 2'd2;
  localparam logic [1:0] SEL_XBUF = 2'd3;

  logic [1:0] ld_ack_sync, tx_empty_sync, uld_ack_sync, rx_empty_sync;
  logic       ld_ack_s, tx_empty_s, uld_ack_s, rx_empty_s;

  logic [1:0] rx_state, rx_state_next;
  logic [1:0] tx_state, tx_state_next;

  logic       rx_done, rx_ie, tx_ready, tx_ie;
  logic [7:0] rbuf;

  logic       hit;
  logic [1:0] sel;
  logic       wr_low;
  logic       rd_rbuf, wr_rcsr, wr_xcsr, wr_xbuf;
  logic       rx_capture, tx_finish, tx_accept;
  logic       unused_bits;

  // Two-flop synchronizers; every uart output is asynchronous to clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_ack_sync   <= 2'b00;
      uld_ack_sync  <= 2'b00;
      tx_empty_sync <= 2'b11;
      rx_empty_sync <= 2'b11;
    end else begin
      ld_ack_sync   <= {ld_ack_sync[0], ld_tx_ack};
      uld_ack_sync  <= {uld_ack_sync[0], uld_rx_ack};
      tx_empty_sync <= {tx_empty_sync[0], tx_empty};
      rx_empty_sync <= {rx_empty_sync[0], rx_empty};
    end
  end

  assign ld_ack_s   = ld_ack_sync[1];
  assign uld_ack_s  = uld_ack_sync[1];
  assign tx_empty_s = tx_empty_sync[1];
  assign rx_empty_s = rx_empty_sync[1];

  // Address decode; high-byte writes are discarded, low-byte writes act as word writes.
  assign hit     = (bus.iopage_addr[12:3] == BASE_ADDR[12:3]);
  assign sel     = bus.iopage_addr[2:1];
  assign wr_low  = bus.iopage_wr && hit && !(bus.iopage_byte_op && bus.iopage_addr[0]);
  assign rd_rbuf = bus.iopage_rd && hit && (sel == SEL_RBUF);
  assign wr_rcsr = wr_low && (sel == SEL_RCSR);
  assign wr_xcsr = wr_low && (sel == SEL_XCSR);
  assign wr_xbuf = wr_low && (sel == SEL_XBUF);

  assign unused_bits = ^{bus.data_in[15:7], bus.data_in[5:0]};

  always_comb begin
    bus.data_out = 16'd0;
    bus.decode   = hit;
    if (hit) begin
      case (sel)
        SEL_RCSR: bus.data_out = {8'd0, rx_done, rx_ie, 6'd0};
        SEL_RBUF: bus.data_out = {8'd0, rbuf};
        SEL_XCSR: bus.data_out = {8'd0, tx_ready, tx_ie, 6'd0};
        default:  bus.data_out = 16'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= R_IDLE;
      tx_state <= T_IDLE;
    end else begin
      rx_state <= rx_state_next;
      tx_state <= tx_state_next;
    end
  end

  // Receive unload: only starts with no character held and the previous ack fully released.
  always_comb begin
    rx_state_next = rx_state;
    case (rx_state)
      R_IDLE:  if (!rx_done && !rx_empty_s && !uld_ack_s) rx_state_next = R_REQ;
      R_REQ:   if (uld_ack_s)  rx_state_next = R_ACK;
      R_ACK:   if (!uld_ack_s) rx_state_next = R_IDLE;
      default: rx_state_next = R_IDLE;
    endcase
  end

  // Transmit load: an accepted XBUF write leaves T_IDLE with READY low until the old ack clears.
  always_comb begin
    tx_state_next = tx_state;
    case (tx_state)
      T_IDLE:  if (!tx_ready && !ld_ack_s) tx_state_next = T_REQ;
      T_REQ:   if (ld_ack_s)   tx_state_next = T_ACK;
      T_ACK:   if (!ld_ack_s)  tx_state_next = T_DRAIN;
      T_DRAIN: if (tx_empty_s) tx_state_next = T_IDLE;
      default: tx_state_next = T_IDLE;
    endcase
  end

  assign rx_capture = (rx_state == R_ACK) && !uld_ack_s;
  assign tx_finish  = (tx_state == T_DRAIN) && tx_empty_s;
  assign tx_accept  = wr_xbuf && tx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_done      <= 1'b0;
      rx_ie        <= 1'b0;
      rbuf         <= 8'd0;
      tx_ready     <= 1'b1;
      tx_ie        <= 1'b0;
      tx_data      <= 8'd0;
      ld_tx_req    <= 1'b0;
      uld_rx_req   <= 1'b0;
      interrupt_rx <= 1'b0;
      interrupt_tx <= 1'b0;
    end else begin
      // A fresh character wins over a concurrent RBUF read.
      if (rx_capture) begin
        rx_done <= 1'b1;
        rbuf    <= rx_data;
      end else if (rd_rbuf) begin
        rx_done <= 1'b0;
      end
      if (wr_rcsr) rx_ie <= bus.data_in[6];
      if (wr_xcsr) tx_ie <= bus.data_in[6];
      if (tx_finish) begin
        tx_ready <= 1'b1;
      end else if (tx_accept) begin
        tx_ready <= 1'b0;
        tx_data  <= bus.data_in[7:0];
      end
      ld_tx_req    <= (tx_state_next == T_REQ);
      uld_rx_req   <= (rx_state_next == R_REQ);
      interrupt_rx <= rx_done && rx_ie;
      interrupt_tx <= tx_ready && tx_ie;
    end
  end

endmodule
